seq_controller: RTL and testbench
=================================

# seq_controller

Multi-cycle sequencer for the Y86-64 SEQ processor. It owns the architectural PC and steps the datapath through fetch, decode, execute, memory, writeback and PC update, one stage per state. Each state issues a one-hot stage enable, waits on the data-memory handshake, selects the next PC, and latches the processor status code. It sits above the fetch/decode/execute/memory/writeback stage modules and is the only block that writes PC.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset
- MEM_TIMEOUT, 15, maximum cycles in MEMORY waiting for mem_ack before an ADR fault

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- icode  in  4  instruction code from fetch, valid at the end of FETCH
- f_stat  in  3  fetch status (001 AOK, 010 HLT, 011 ADR, 100 INS), valid at the end of FETCH
- cnd  in  1  condition result from execute, valid at the end of EXECUTE
- valC, valP, valM  in  64 each  constant, fall-through PC, and memory read value
- mem_ack  in  1  data memory done
- mem_err  in  1  data memory address error, qualified by mem_ack
- pc  out  64  current PC, driven to fetch
- f_en, d_en, e_en, m_en, w_en  out  1 each  stage enables; exactly one high per active stage state
- mem_req  out  1  data memory request
- stat  out  3  processor status
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- instr_count  out  32  count of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: when start is high, go to FETCH. start is ignored in every other state.
- FETCH: f_en is high. At the end of the cycle, sample f_stat.
  - f_stat not AOK: stat <= f_stat, go to HALT. PC is not updated, so for HLT the PC stays at the halt instruction.
  - f_stat AOK: go to DECODE.
- DECODE to EXECUTE to the next state, one cycle each, with d_en and e_en respectively. Latch cnd at the end of EXECUTE.
- After EXECUTE:
  - icode in {4,5,8,9,A,B}: go to MEMORY.
  - Any other icode: go to WRITEBACK.
- MEMORY: m_en and mem_req are high until mem_ack.
  - mem_ack with mem_err: stat <= ADR, go to HALT.
  - mem_ack without mem_err: go to WRITEBACK.
  - A wait counter reaching MEM_TIMEOUT without mem_ack: stat <= ADR, go to HALT.
- WRITEBACK: w_en is high for one cycle, then go to PCUPD.
- PCUPD: PC <= next PC, instr_count increments with 32-bit wrap, then go to FETCH. Next PC selection:
  - icode 8 (call): valC
  - icode 7 (jXX): valC if the latched cnd is 1, else valP
  - icode 9 (ret): valM
  - otherwise: valP
- HALT: sticky. All enables and mem_req are 0. It is left only through rst_n.

## Timing
- Reset values:
  - state IDLE
  - pc RESET_PC
  - stat 001 (AOK)
  - instr_count 0
  - all enables, mem_req, busy and halted 0
- Enables and mem_req are decoded combinationally from the state register. Stage modules capture their inputs on the rising edge that ends the stage cycle.
- start is sampled at edge 0. FETCH occupies cycle 1.
- Non-memory instruction: 5 cycles from FETCH to the next FETCH.
- Memory instruction with mem_ack in the first MEMORY cycle: 6 cycles. Each wait cycle adds 1.
- mem_ack arriving in the same cycle the wait counter reaches MEM_TIMEOUT counts as an ack, not a timeout.
- mem_ack outside MEMORY is ignored.
- rst_n low at any time, including mid-MEMORY, forces reset values immediately and drops mem_req asynchronously.

## Configuration
- SEQ_STEP_EN defined:
  - Adds input port step (1 bit) and state PAUSE.
  - PCUPD goes to PAUSE instead of FETCH. PAUSE goes to FETCH on a step pulse.
  - busy is 0 in PAUSE.
  - start in IDLE behaves as in the undefined case.
- SEQ_STEP_EN undefined: the step port and PAUSE state do not exist, and PCUPD goes directly to FETCH.

## Structure
- Shared package y86_pkg:
  - icode constants (HALT through POPQ)
  - stat encodings STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS
  - the controller state enum
  - a function is_mem_icode
- One combinational sub-module seq_pc_select holds the next-PC mux (icode, cnd, valC, valP, valM to new_pc).
- The FSM, wait counter, PC register and instruction counter stay in seq_controller.

## Test plan
- Reset, then start with icode 6, f_stat AOK, valP 2:
  - enables pulse f, d, e, w in cycles 1 to 4, with no m_en and no mem_req.
  - pc becomes 2 after PCUPD (cycle 5) and instr_count becomes 1.
- icode 5, mem_ack delayed 3 cycles:
  - mem_req is high for exactly 3 cycles.
  - The instruction takes 8 cycles and pc = valP.
- icode 7, valC 0x40, valP 0x9:
  - cnd 1 gives pc 0x40.
  - cnd 0 gives pc 0x9.
- icode 9, valM 0x123, mem_ack immediate: pc becomes 0x123.
- f_stat 010 at FETCH: stat becomes 010 and halted = 1, pc is unchanged, and a later start is ignored.
- icode 4 with mem_ack held low for MEMORY_TIMEOUT cycles: stat becomes 011 and HALT is entered.
- Assert rst_n low mid-MEMORY:
  - mem_req drops immediately.
  - pc returns to RESET_PC and stat to 001.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 SEQ sequencer.
//   - icode constants (I_HALT .. I_POPQ)
//   - processor status encodings (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS)
//   - controller state enum (ST_PAUSE exists only when SEQ_STEP_EN is defined)
//   - is_mem_icode(): instructions that need the data-memory stage
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [2:0] STAT_HLT = 3'b010;
  localparam logic [2:0] STAT_ADR = 3'b011;
  localparam logic [2:0] STAT_INS = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXECUTE   = 4'd3,
    ST_MEMORY    = 4'd4,
    ST_WRITEBACK = 4'd5,
    ST_PCUPD     = 4'd6,
`ifdef SEQ_STEP_EN
    ST_PAUSE     = 4'd8,
`endif
    ST_HALT      = 4'd7
  } seq_state_e;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
  endfunction

endpackage

// File: rtl/seq_pc_select.sv
// seq_pc_select: combinational next-PC mux for the SEQ sequencer.
// Ports:
//   icode  in  4   instruction code of the retiring instruction
//   cnd    in  1   latched branch condition
//   valC   in  64  instruction constant (call / jump target)
//   valP   in  64  fall-through PC
//   valM   in  64  value read from memory (return address)
//   new_pc out 64  PC for the next instruction
module seq_pc_select
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] new_pc
);

  always_comb begin
    new_pc = valP;
    case (icode)
      I_CALL:  new_pc = valC;
      I_JXX:   new_pc = cnd ? valC : valP;
      I_RET:   new_pc = valM;
      default: new_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle sequencer for the Y86-64 SEQ processor.
// Owns the architectural PC, steps the datapath one stage per state, waits on
// the data-memory handshake with a timeout, and latches the status code.
// Optional build macro: SEQ_STEP_EN adds a 'step' input and a PAUSE state
// entered after every PC update (single-step debug).
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   pulse, leaves IDLE
//   step         in   1   (SEQ_STEP_EN only) pulse, leaves PAUSE
//   icode        in   4   instruction code, valid at end of FETCH
//   f_stat       in   3   fetch status, valid at end of FETCH
//   cnd          in   1   condition result, valid at end of EXECUTE
//   valC/P/M     in   64  constant, fall-through PC, memory read value
//   mem_ack      in   1   data memory done
//   mem_err      in   1   data memory address error (qualified by mem_ack)
//   pc           out  64  current PC
//   f/d/e/m/w_en out  1   one-hot stage enables
//   mem_req      out  1   data memory request
//   stat         out  3   processor status
//   busy         out  1   sequencing an instruction
//   halted       out  1   in HALT
//   instr_count  out  32  retired instruction count (wraps)
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | f_en, sample f_stat and icode
// DECODE    | d_en
// EXECUTE   | e_en, latch cnd, pick MEMORY or WRITEBACK
// MEMORY    | m_en + mem_req until mem_ack or timeout
// WRITEBACK | w_en
// PCUPD     | commit next PC, count instruction
// PAUSE     | (SEQ_STEP_EN) wait for step
// HALT      | sticky until reset
module seq_controller
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic [3:0]  icode,
  input  logic [2:0]  f_stat,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic [63:0] pc,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        halted,
  output logic [31:0] instr_count
);

  // Down-counter holds the MEMORY cycles still allowed after the current one;
  // reaching zero without an ack in the same cycle is the timeout.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [3:0]        icode_q;
  logic              cnd_q;
  logic [63:0]       new_pc;
  logic              fetch_fault;
  logic              mem_fault;

  seq_pc_select u_pc_select (
    .icode  (icode_q),
    .cnd    (cnd_q),
    .valC   (valC),
    .valP   (valP),
    .valM   (valM),
    .new_pc (new_pc)
  );

  assign fetch_fault = (state_q == ST_FETCH) && (f_stat != STAT_AOK);
  // An ack in the last allowed cycle wins over the timeout.
  assign mem_fault   = (state_q == ST_MEMORY) &&
                       ((mem_ack && mem_err) || (!mem_ack && (wait_q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    f_en    = 1'b0;
    d_en    = 1'b0;
    e_en    = 1'b0;
    m_en    = 1'b0;
    w_en    = 1'b0;
    mem_req = 1'b0;
    busy    = 1'b1;
    halted  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        f_en    = 1'b1;
        state_d = fetch_fault ? ST_HALT : ST_DECODE;
      end
      ST_DECODE: begin
        d_en    = 1'b1;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        e_en    = 1'b1;
        state_d = is_mem_icode(icode_q) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        m_en    = 1'b1;
        mem_req = 1'b1;
        if (mem_fault)    state_d = ST_HALT;
        else if (mem_ack) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_en    = 1'b1;
        state_d = ST_PCUPD;
      end
      ST_PCUPD: begin
`ifdef SEQ_STEP_EN
        state_d = ST_PAUSE;
`else
        state_d = ST_FETCH;
`endif
      end
`ifdef SEQ_STEP_EN
      ST_PAUSE: begin
        busy = 1'b0;
        if (step) state_d = ST_FETCH;
      end
`endif
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // icode is only guaranteed at the end of FETCH, but it steers the
  // EXECUTE branch and the PCUPD mux, so it is held locally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icode_q <= I_HALT;
      cnd_q   <= 1'b0;
      wait_q  <= WAIT_LOAD;
    end else begin
      if (state_q == ST_FETCH)   icode_q <= icode;
      if (state_q == ST_EXECUTE) begin
        cnd_q  <= cnd;
        wait_q <= WAIT_LOAD;
      end else if ((state_q == ST_MEMORY) && (wait_q != '0)) begin
        wait_q <= wait_q - WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      stat        <= STAT_AOK;
      instr_count <= 32'd0;
    end else begin
      if (fetch_fault)    stat <= f_stat;
      else if (mem_fault) stat <= STAT_ADR;
      if (state_q == ST_PCUPD) begin
        pc          <= new_pc;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
module tb_seq_controller;
  import y86_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_0000_0100;
  localparam int          TO  = 15;
`ifdef SEQ_STEP_EN
  localparam int          EXTRA = 1;
`else
  localparam int          EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b1;
  logic [3:0]  icode = 4'h0;
  logic [2:0]  f_stat = STAT_AOK;
  logic        cnd = 1'b0;
  logic [63:0] valC = '0, valP = '0, valM = '0;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [63:0] pc;
  logic        f_en, d_en, e_en, m_en, w_en, mem_req, busy, halted;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  seq_controller #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .icode(icode), .f_stat(f_stat), .cnd(cnd),
    .valC(valC), .valP(valP), .valM(valM),
    .mem_ack(mem_ack), .mem_err(mem_err),
    .pc(pc), .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .mem_req(mem_req), .stat(stat), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          halt;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic [2:0]  stat;
    int          len;
    logic [39:0] en;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cur_delay = 0;
  bit          cur_err = 1'b0;
  logic [63:0] model_pc = RPC;
  logic [31:0] model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the cur_delay-th MEMORY cycle (0 = never);
  // outside MEMORY it drives random junk on ack/err that must be ignored.
  initial begin
    int mc = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mc++;
        mem_ack = (cur_delay != 0) && (mc == cur_delay);
        mem_err = mem_ack && cur_err;
      end else begin
        mc = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_err = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: an instruction retiring (instr_count moves) or HALT being
  // entered pops the next expectation and compares it.
  initial begin
    int cyc = 0, fcyc = 0, bad = 0;
    int nf = 0, nd = 0, ne = 0, nm = 0, nw = 0;
    logic [31:0] last_cnt = 0;
    bit last_h = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_cnt = 0; last_h = 1'b0; bad = 0;
        nf = 0; nd = 0; ne = 0; nm = 0; nw = 0;
        continue;
      end
      if ((instr_count !== last_cnt) || (halted && !last_h)) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=count %0h halted %0b required=none", instr_count, halted);
        end else begin
          e = exp_q.pop_front();
          check("halted", 64'(halted), 64'(e.halt));
          check("pc", pc, e.pc);
          check("instr_count", 64'(instr_count), 64'(e.cnt));
          check("stat", 64'(stat), 64'(e.stat));
          check("cycles", 64'(cyc - fcyc), 64'(e.len));
          check("enable_counts", 64'({8'(nf), 8'(nd), 8'(ne), 8'(nm), 8'(nw)}), 64'(e.en));
          check("enable_rules", 64'(bad), 64'd0);
        end
      end
      last_cnt = instr_count;
      last_h = halted;
      if (f_en) begin
        fcyc = cyc; bad = 0;
        nf = 0; nd = 0; ne = 0; nm = 0; nw = 0;
      end
      nf += int'(f_en); nd += int'(d_en); ne += int'(e_en); nm += int'(m_en); nw += int'(w_en);
      if (($countones({f_en, d_en, e_en, m_en, w_en}) > 1) || (mem_req !== m_en) || (halted && busy))
        bad++;
    end
  end

  function automatic logic [63:0] ref_next_pc(input logic [3:0] ic, input logic c,
                                               input logic [63:0] vc, vp, vm);
    if (ic == 4'h8) return vc;
    if (ic == 4'h7) return c ? vc : vp;
    if (ic == 4'h9) return vm;
    return vp;
  endfunction

  task automatic run_instr(input logic [3:0] ic, input logic [2:0] fs, input logic c,
                           input logic [63:0] vc, vp, vm, input int dly, input bit err);
    exp_t e;
    bit mem, got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (f_en) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL fetch_wait actual=no_fetch required=fetch");
      return;
    end
    icode = ic; f_stat = fs; cnd = c; valC = vc; valP = vp; valM = vm;
    cur_delay = dly; cur_err = err;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    e.pc = model_pc; e.cnt = model_cnt;
    if (fs != STAT_AOK) begin
      e.halt = 1'b1; e.stat = fs; e.len = 1; e.en = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    end else if (mem && (dly == 0 || dly > TO)) begin
      e.halt = 1'b1; e.stat = STAT_ADR; e.len = 3 + TO; e.en = {8'd1, 8'd1, 8'd1, 8'(TO), 8'd0};
    end else if (mem && err) begin
      e.halt = 1'b1; e.stat = STAT_ADR; e.len = 3 + dly; e.en = {8'd1, 8'd1, 8'd1, 8'(dly), 8'd0};
    end else begin
      model_pc = ref_next_pc(ic, c, vc, vp, vm);
      model_cnt = model_cnt + 1;
      e.halt = 1'b0; e.stat = STAT_AOK; e.pc = model_pc; e.cnt = model_cnt;
      e.len = 5 + (mem ? dly : 0) + EXTRA;
      e.en = {8'd1, 8'd1, 8'd1, (mem ? 8'(dly) : 8'd0), 8'd1};
    end
    exp_q.push_back(e);
    if (e.halt) begin
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (halted) begin got = 1'b1; break; end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL halt_wait actual=not_halted required=halted");
      end
    end
  endtask

  task automatic run_random();
    logic [3:0] ic;
    int dly;
    ic = 4'($urandom_range(0, 11));
    dly = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 4);
    run_instr(ic, STAT_AOK, 1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, dly, 1'b0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc, RPC);
    check("rst_stat", 64'(stat), 64'(STAT_AOK));
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_outputs", 64'({f_en, d_en, e_en, m_en, w_en, mem_req, busy, halted}), 64'd0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RPC;
    model_cnt = 0;
  endtask

  task automatic check_start_ignored(input logic [2:0] exp_stat);
    start_pulse();
    repeat (8) @(negedge clk);
    check("halt_sticky", 64'({halted, busy, f_en}), 64'b100);
    check("halt_pc", pc, model_pc);
    check("halt_stat", 64'(stat), 64'(exp_stat));
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_busy", 64'({busy, f_en}), 64'd0);

    start_pulse();
    run_instr(4'h6, STAT_AOK, 1'b0, 64'h0, 64'h2, 64'h0, 1, 1'b0);
    run_instr(4'h5, STAT_AOK, 1'b0, 64'h0, 64'h1a, 64'h0, 3, 1'b0);
    run_instr(4'h7, STAT_AOK, 1'b1, 64'h40, 64'h9, 64'h0, 1, 1'b0);
    run_instr(4'h7, STAT_AOK, 1'b0, 64'h40, 64'h9, 64'h0, 1, 1'b0);
    run_instr(4'h9, STAT_AOK, 1'b0, 64'h0, 64'h11, 64'h123, 1, 1'b0);
    run_instr(4'h8, STAT_AOK, 1'b0, 64'h500, 64'h13, 64'h0, 2, 1'b0);
    run_instr(4'h4, STAT_AOK, 1'b0, 64'h0, 64'h20, 64'h0, TO, 1'b0);
    for (int i = 0; i < 40; i++) run_random();
    run_instr(4'h4, STAT_AOK, 1'b0, 64'h0, 64'h30, 64'h0, 0, 1'b0);
    check_start_ignored(STAT_ADR);

    do_reset();
    start_pulse();
    for (int i = 0; i < 5; i++) run_random();
    run_instr(4'h0, STAT_HLT, 1'b0, 64'h0, 64'h1, 64'h0, 1, 1'b0);
    check_start_ignored(STAT_HLT);

    do_reset();
    start_pulse();
    run_instr(4'h3, STAT_AOK, 1'b0, 64'h0, 64'h44, 64'h0, 1, 1'b0);
    run_instr(4'hA, STAT_AOK, 1'b0, 64'h0, 64'h4e, 64'h0, 2, 1'b1);
    check_start_ignored(STAT_ADR);

    do_reset();
    start_pulse();
    run_instr(4'h6, STAT_AOK, 1'b0, 64'h0, 64'h77, 64'h0, 1, 1'b0);
    // Next instruction stalls in MEMORY; reset lands mid-request.
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (f_en) begin got = 1'b1; break; end
    end
    icode = 4'h5; f_stat = STAT_AOK; cur_delay = 0; cur_err = 1'b0;
    for (int i = 0; i < 100 && got; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("mem_req_before_reset", 64'({got, mem_req}), 64'b11);
    check("pc_before_reset", pc, 64'h77);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mem_req_async_drop", 64'({mem_req, m_en}), 64'd0);
    check_reset_values();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({busy, halted, f_en}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
